// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bundle: hazard/wait/exception requests coming in from the
// pipeline stages, and the stall/flush/divider/redirect controls going back.
// The controller uses the slave modport. The pipeline side, or a bench, uses the master modport.
interface pipeline_ctrl_if;
    // Requests into the controller
    logic       hazard_stall_ID;
    logic       div_valid_EX;
    logic       dmem_wait;
    logic       imem_wait;
    logic       exc_MEM;
    // Controls out of the controller
    logic       stall_IF;
    logic       stall_ID;
    logic       stall_EX;
    logic       stall_MEM;
    logic       flush_ID;
    logic       flush_EX;
    logic       flush_MEM;
    logic       div_busy;
    logic       div_done;
    logic       pc_redirect;
    // FSM state exposed for checkers (0 RUN, 1 DIV, 2 FLUSH)
    logic [1:0] state_dbg;

    modport master (
        output hazard_stall_ID, div_valid_EX, dmem_wait, imem_wait, exc_MEM,
        input  stall_IF, stall_ID, stall_EX, stall_MEM,
        input  flush_ID, flush_EX, flush_MEM,
        input  div_busy, div_done, pc_redirect, state_dbg
    );

    modport slave (
        input  hazard_stall_ID, div_valid_EX, dmem_wait, imem_wait, exc_MEM,
        output stall_IF, stall_ID, stall_EX, stall_MEM,
        output flush_ID, flush_EX, flush_MEM,
        output div_busy, div_done, pc_redirect, state_dbg
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller for a 5-stage MIPS-style core.
// It owns the multi-cycle divider occupancy and the exception redirect bubble.
// Stall and flush controls are combinational from the current requests and the state.
// Priority: exception > data-memory wait > divider > load-use hazard > fetch wait.
// No handshake runs through this block: every request is a level that is sampled each cycle.
// Every control is a level that is valid in the same cycle.
module pipeline_ctrl #(
    parameter int DIV_CYCLES = 33
) (
    input  logic          clk,
    input  logic          resetn,
    pipeline_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DIV   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    state_t     state_q, state_d;
    logic [5:0] cnt_q,   cnt_d;

    logic s_if, s_id, s_ex, s_mem;
    logic f_id, f_ex, f_mem;
    logic done;

    // Last divide cycle: the count is exhausted and memory is not freezing EX.
    // An exception in the same cycle aborts the division, so no result is written.
    assign done = (state_q == ST_DIV) && (cnt_q == 6'd0) &&
                  !bus.dmem_wait && !bus.exc_MEM;

    // State and counter registers, cleared asynchronously
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_RUN;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.exc_MEM) begin
            state_d = ST_FLUSH;
            cnt_d   = 6'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.div_valid_EX) begin
                        state_d = ST_DIV;
                        cnt_d   = DIV_LOAD;
                    end
                end
                ST_DIV: begin
                    // A memory freeze also holds the divider count
                    if (!bus.dmem_wait) begin
                        if (cnt_q == 6'd0) begin
                            state_d = ST_RUN;
                        end else begin
                            cnt_d = cnt_q - 6'd1;
                        end
                    end
                end
                ST_FLUSH: begin
                    // div_valid_EX is a squashed instruction here, so it is ignored
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 6'd0;
                end
            endcase
        end
    end

    // Stall/flush decode in priority order; reset forces bubbles everywhere
    always_comb begin
        s_if  = 1'b0;
        s_id  = 1'b0;
        s_ex  = 1'b0;
        s_mem = 1'b0;
        f_id  = 1'b0;
        f_ex  = 1'b0;
        f_mem = 1'b0;
        if (!resetn) begin
            f_id  = 1'b1;
            f_ex  = 1'b1;
            f_mem = 1'b1;
        end else if (bus.exc_MEM) begin
            f_id  = 1'b1;
            f_ex  = 1'b1;
            f_mem = 1'b1;
        end else if (state_q == ST_FLUSH) begin
            // The redirect cycle: the instruction fetched down the old path is dropped
            f_id  = 1'b1;
        end else if (bus.dmem_wait) begin
            s_if  = 1'b1;
            s_id  = 1'b1;
            s_ex  = 1'b1;
            s_mem = 1'b1;
        end else if ((state_q == ST_DIV) && !done) begin
            s_if  = 1'b1;
            s_id  = 1'b1;
            s_ex  = 1'b1;
            f_mem = 1'b1;
        end else if (bus.hazard_stall_ID) begin
            s_if  = 1'b1;
            s_id  = 1'b1;
            f_ex  = 1'b1;
        end else if (bus.imem_wait) begin
            s_if  = 1'b1;
            f_id  = 1'b1;
        end
    end

    assign bus.stall_IF    = s_if;
    assign bus.stall_ID    = s_id;
    assign bus.stall_EX    = s_ex;
    assign bus.stall_MEM   = s_mem;
    assign bus.flush_ID    = f_id;
    assign bus.flush_EX    = f_ex;
    assign bus.flush_MEM   = f_mem;
    assign bus.div_busy    = (state_q == ST_DIV);
    assign bus.div_done    = done;
    assign bus.pc_redirect = (state_q == ST_FLUSH);
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl. A behavioural model tracks the divider's remaining work
// and the pending redirect. Directed scenarios and randomized traffic are compared
// against that model every cycle.
module tb_pipeline_ctrl;

    localparam int DIV_CYCLES = 33;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    pipeline_ctrl_if bus ();

    pipeline_ctrl #(.DIV_CYCLES(DIV_CYCLES)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // {stall_IF,ID,EX,MEM, flush_ID,EX,MEM, div_busy, div_done, pc_redirect}
    logic [9:0] dut_outs;
    assign dut_outs = {bus.stall_IF, bus.stall_ID, bus.stall_EX, bus.stall_MEM,
                       bus.flush_ID, bus.flush_EX, bus.flush_MEM,
                       bus.div_busy, bus.div_done, bus.pc_redirect};

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // m_left counts the non-frozen divider cycles still owed. The result appears
    // in the cycle that consumes the last one.
    bit m_busy     = 1'b0;
    bit m_redirect = 1'b0;
    int m_left     = 0;

    function automatic logic [9:0] model_outs(input bit hz, input bit dw, input bit iw,
                                              input bit ex, input bit rst_n);
        logic [3:0] st;
        logic [2:0] fl;
        bit         dn;
        if (!rst_n) return 10'b0000_111_000;
        dn = m_busy && (m_left == 1) && !dw && !ex;
        st = 4'b0000;
        fl = 3'b000;
        if (ex)                 fl = 3'b111;
        else if (m_redirect)    fl = 3'b100;
        else if (dw)            st = 4'b1111;
        else if (m_busy && !dn) begin st = 4'b1110; fl = 3'b001; end
        else if (hz)            begin st = 4'b1100; fl = 3'b010; end
        else if (iw)            begin st = 4'b1000; fl = 3'b100; end
        return {st, fl, m_busy, dn, m_redirect};
    endfunction

    task automatic model_clock(input bit dv, input bit dw, input bit ex);
        if (ex) begin
            m_busy     = 1'b0;
            m_left     = 0;
            m_redirect = 1'b1;
        end else if (m_redirect) begin
            m_redirect = 1'b0;
        end else if (m_busy) begin
            if (!dw) begin
                m_left = m_left - 1;
                if (m_left == 0) m_busy = 1'b0;
            end
        end else if (dv) begin
            m_busy = 1'b1;
            m_left = DIV_CYCLES;
        end
    endtask

    task automatic model_reset();
        m_busy     = 1'b0;
        m_redirect = 1'b0;
        m_left     = 0;
    endtask

    // ---------------- driver ----------------
    bit last_busy, last_done, last_redir;

    task automatic step(input bit hz, input bit dv, input bit dw, input bit iw, input bit ex);
        @(negedge clk);
        bus.hazard_stall_ID = hz;
        bus.div_valid_EX    = dv;
        bus.dmem_wait       = dw;
        bus.imem_wait       = iw;
        bus.exc_MEM         = ex;
        #1;
        check("outs", 32'(dut_outs), 32'(model_outs(hz, dw, iw, ex, 1'b1)));
        last_busy  = bus.div_busy;
        last_done  = bus.div_done;
        last_redir = bus.pc_redirect;
        @(posedge clk);
        model_clock(dv, dw, ex);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("reset_outs", 32'(dut_outs), 32'(model_outs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0)));
        model_reset();
        @(negedge clk);
        check("reset_hold", 32'(dut_outs), 32'(model_outs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0)));
        resetn = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int busy_cnt, done_at, done_cnt, redir_cnt;

    initial begin
        resetn              = 1'b0;
        bus.hazard_stall_ID = 1'b0;
        bus.div_valid_EX    = 1'b0;
        bus.dmem_wait       = 1'b0;
        bus.imem_wait       = 1'b0;
        bus.exc_MEM         = 1'b0;
        #2;
        check("por_outs", 32'(dut_outs), 32'(10'b0000_111_000));
        apply_reset();

        // Plain division: busy for 33 cycles, result on the 33rd
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        busy_cnt = 0; done_at = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            if (last_busy) busy_cnt++;
            if (last_done) done_at = busy_cnt;
        end
        check("busy_len", busy_cnt, DIV_CYCLES);
        check("done_at", done_at, DIV_CYCLES);

        // Division with a 5-cycle memory freeze mid-count
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        done_at = 0;
        for (int i = 1; i <= 45; i++) begin
            if (i >= 10 && i < 15) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            else idle();
            if (last_done) done_at = i;
        end
        check("done_lat_wait", done_at, DIV_CYCLES + 5);

        // Exception at division cycle 10: abort, one redirect cycle
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 10; i++) idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        done_cnt = 0; redir_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            if (last_done)  done_cnt++;
            if (last_redir) redir_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        check("redirect_once", redir_cnt, 1);

        // Load-use hazard together with a fetch wait
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Back-to-back division requests: the second starts right after the result
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 70; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 35; i++) idle();

        // Reset at division cycle 20, then a fresh division
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 20; i++) idle();
        apply_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        busy_cnt = 0; done_at = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            if (last_busy) busy_cnt++;
            if (last_done) done_at = busy_cnt;
        end
        check("post_reset_done_at", done_at, DIV_CYCLES);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 59) == 0);
            if ($urandom_range(0, 999) == 0) apply_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
